// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package icache_pkg;

    // Byte-offset bits inside a line; lines are always one 32-bit word.
    localparam int OFFW = 2;

    // Ceiling log2, usable in parameter/localparam expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Number of sets for a given geometry.
    function automatic int num_sets(input int cachesize, input int blocksize, input int assoc);
        return cachesize / (blocksize * assoc);
    endfunction

    // Index field width for a given geometry.
    function automatic int index_width(input int cachesize, input int blocksize, input int assoc);
        return clog2(num_sets(cachesize, blocksize, assoc));
    endfunction

    // Tag field width: whatever remains of a 32-bit address above index and offset.
    function automatic int tag_width(input int cachesize, input int blocksize, input int assoc);
        return 32 - index_width(cachesize, blocksize, assoc) - OFFW;
    endfunction

    // Geometry of the default configuration (1 KiB, 4-byte lines, 2 ways).
    localparam int DEF_NSETS = num_sets(1024, 4, 2);
    localparam int DEF_IDXW  = index_width(1024, 4, 2);
    localparam int DEF_TAGW  = tag_width(1024, 4, 2);

    typedef enum logic {
        IDLE         = 1'b0,
        MISS_PENDING = 1'b1
    } state_t;

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bit, tag and 32-bit data word.
// Latency: combinational read by rd_index; write lands on the rising clk edge.
// Backpressure: none; a write with wr_en=1 is always accepted.
// Ports: clk/reset (async active-low, clears valid bits only), rd_index ->
// rd_valid/rd_tag/rd_data, wr_en/wr_index/wr_tag/wr_data write a line and set it valid.
module icache_way #(
    parameter int IDXW = 7,
    parameter int TAGW = 23
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IDXW-1:0] rd_index,
    output logic            rd_valid,
    output logic [TAGW-1:0] rd_tag,
    output logic [31:0]     rd_data,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_index,
    input  logic [TAGW-1:0] wr_tag,
    input  logic [31:0]     wr_data
);

    localparam int NSETS = 1 << IDXW;

    logic [NSETS-1:0] valid_bits;
    logic [TAGW-1:0]  tag_mem  [NSETS];
    logic [31:0]      data_mem [NSETS];

    // Only the valid bits need resetting; tag/data contents are don't-care
    // until their valid bit is set, so they stay plain storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_bits <= '0;
        end else if (wr_en) begin
            valid_bits[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_bits[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache_set_assoc.sv
// Blocking read-only set-associative instruction cache, one word per line, FIFO replacement.
// Latency: hit/miss registered 1 cycle after instraddress; a miss holds until iready fills the line.
// Backpressure: while a miss is pending, instraddress is ignored until the memory strobes iready.
// Ports: clk, reset (async active-low); instraddress lookup request; ifetch/iready memory reply;
// instruction/hit/miss registered lookup result; fetchaddr word-aligned miss address to memory.
module icache_set_assoc
    import icache_pkg::*;
#(
    parameter int CACHESIZE     = 1024,
    parameter int BLOCKSIZE     = 4,
    parameter int ASSOCIATIVITY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ifetch,
    input  logic [31:0] instraddress,
    input  logic        iready,
    output logic [31:0] instruction,
    output logic        hit,
    output logic        miss,
    output logic [31:0] fetchaddr
);

    localparam int NSETS = num_sets(CACHESIZE, BLOCKSIZE, ASSOCIATIVITY);
    localparam int IDXW  = index_width(CACHESIZE, BLOCKSIZE, ASSOCIATIVITY);
    localparam int TAGW  = tag_width(CACHESIZE, BLOCKSIZE, ASSOCIATIVITY);
    localparam int PTRW  = clog2(ASSOCIATIVITY);
    // A direct-mapped cache has no pointer; keep one bit that is held at zero.
    localparam int PW    = (PTRW > 0) ? PTRW : 1;

    generate
        if (BLOCKSIZE != 4) begin : g_bad_blocksize
            $error("icache_set_assoc: only BLOCKSIZE=4 is supported");
        end
        if (ASSOCIATIVITY < 1 || (1 << PTRW) != ASSOCIATIVITY) begin : g_bad_assoc
            $error("icache_set_assoc: ASSOCIATIVITY must be a power of two >= 1");
        end
        if (NSETS < 2 || (1 << IDXW) != NSETS) begin : g_bad_nsets
            $error("icache_set_assoc: number of sets must be a power of two >= 2");
        end
    endgenerate

    // Address split of the incoming lookup.
    logic [IDXW-1:0] cur_idx;
    logic [TAGW-1:0] cur_tag;
    logic [1:0]      unused_offset;
    assign cur_idx       = instraddress[OFFW+IDXW-1:OFFW];
    assign cur_tag       = instraddress[31:OFFW+IDXW];
    assign unused_offset = instraddress[1:0];

    // Registered state.
    state_t          state_q, state_d;
    logic            hit_d, miss_d;
    logic [31:0]     instr_d, fetch_d;
    logic [IDXW-1:0] lat_idx_q, lat_idx_d;
    logic [TAGW-1:0] lat_tag_q, lat_tag_d;
    logic [PW-1:0]   fifo_ptr [NSETS];

    // Way array interface.
    logic [ASSOCIATIVITY-1:0] way_valid;
    logic [ASSOCIATIVITY-1:0] way_we;
    logic [TAGW-1:0]          way_tag  [ASSOCIATIVITY];
    logic [31:0]              way_data [ASSOCIATIVITY];

    logic          fill;
    logic [PW-1:0] victim;
    logic [PW-1:0] victim_next;

    assign fill   = (state_q == MISS_PENDING) && iready;
    assign victim = fifo_ptr[lat_idx_q];
    // Power-of-two way count, so plain PW-bit increment wraps modulo ASSOCIATIVITY.
    assign victim_next = (ASSOCIATIVITY == 1) ? '0 : victim + 1'b1;

    generate
        for (genvar w = 0; w < ASSOCIATIVITY; w++) begin : g_way
            assign way_we[w] = fill && (victim == PW'(w));

            icache_way #(
                .IDXW (IDXW),
                .TAGW (TAGW)
            ) u_way (
                .clk      (clk),
                .reset    (reset),
                .rd_index (cur_idx),
                .rd_valid (way_valid[w]),
                .rd_tag   (way_tag[w]),
                .rd_data  (way_data[w]),
                .wr_en    (way_we[w]),
                .wr_index (lat_idx_q),
                .wr_tag   (lat_tag_q),
                .wr_data  (ifetch)
            );
        end
    endgenerate

    // Parallel tag compare. At most one way can match, so OR-ing the matching
    // data words yields the hit data without a priority mux.
    logic        lookup_hit;
    logic [31:0] lookup_data;
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            if (way_valid[w] && (way_tag[w] == cur_tag)) begin
                lookup_hit  = 1'b1;
                lookup_data = lookup_data | way_data[w];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        hit_d     = hit;
        miss_d    = miss;
        instr_d   = instruction;
        fetch_d   = fetchaddr;
        lat_idx_d = lat_idx_q;
        lat_tag_d = lat_tag_q;
        case (state_q)
            IDLE: begin
                if (lookup_hit) begin
                    hit_d   = 1'b1;
                    miss_d  = 1'b0;
                    instr_d = lookup_data;
                end else begin
                    hit_d     = 1'b0;
                    miss_d    = 1'b1;
                    fetch_d   = {instraddress[31:2], 2'b00};
                    lat_idx_d = cur_idx;
                    lat_tag_d = cur_tag;
                    state_d   = MISS_PENDING;
                end
            end
            MISS_PENDING: begin
                hit_d  = 1'b0;
                miss_d = 1'b1;
                if (iready) begin
                    instr_d = ifetch;
                    miss_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hit         <= 1'b0;
            miss        <= 1'b0;
            instruction <= '0;
            fetchaddr   <= '0;
            lat_idx_q   <= '0;
            lat_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            hit         <= hit_d;
            miss        <= miss_d;
            instruction <= instr_d;
            fetchaddr   <= fetch_d;
            lat_idx_q   <= lat_idx_d;
            lat_tag_q   <= lat_tag_d;
        end
    end

    // Per-set replacement pointer; advances only on a fill, never on a hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NSETS; s++) begin
                fifo_ptr[s] <= '0;
            end
        end else if (fill) begin
            fifo_ptr[lat_idx_q] <= victim_next;
        end
    end

endmodule

// File: tb/tb_icache_set_assoc.sv
module tb_icache_set_assoc;

    localparam int NSETS = 128;
    localparam int WAYS  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ifetch;
    logic [31:0] instraddress;
    logic        iready;
    logic [31:0] instruction;
    logic        hit;
    logic        miss;
    logic [31:0] fetchaddr;

    always #5 clk = ~clk;

    icache_set_assoc #(
        .CACHESIZE     (1024),
        .BLOCKSIZE     (4),
        .ASSOCIATIVITY (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ifetch       (ifetch),
        .instraddress (instraddress),
        .iready       (iready),
        .instruction  (instruction),
        .hit          (hit),
        .miss         (miss),
        .fetchaddr    (fetchaddr)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: each set is a list of resident word addresses in
    // insertion order (oldest first); the cache is blocking, so a single
    // pending-miss flag with its address is enough.
    logic [29:0] line_q [NSETS][$];
    logic [31:0] data_q [NSETS][$];
    bit          pending;
    logic [31:0] pend_addr;
    bit          exp_hit, exp_miss;
    logic [31:0] exp_instr, exp_fetch;

    function automatic int set_of(input logic [31:0] a);
        return int'((a / 4) % NSETS);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'hAA, a[23:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs();
        check("hit", {31'b0, hit}, {31'b0, exp_hit});
        check("miss", {31'b0, miss}, {31'b0, exp_miss});
        check("instruction", instruction, exp_instr);
        check("fetchaddr", fetchaddr, exp_fetch);
    endtask

    task automatic model_reset();
        for (int s = 0; s < NSETS; s++) begin
            line_q[s].delete();
            data_q[s].delete();
        end
        pending   = 0;
        pend_addr = '0;
        exp_hit   = 0;
        exp_miss  = 0;
        exp_instr = '0;
        exp_fetch = '0;
    endtask

    // What the registered outputs must be after the coming rising edge.
    task automatic model_step(input logic [31:0] a, input logic rdy, input logic [31:0] data);
        int  s;
        bit  found;
        logic [31:0] d;
        if (!pending) begin
            s     = set_of(a);
            found = 0;
            d     = '0;
            for (int i = 0; i < line_q[s].size(); i++) begin
                if (line_q[s][i] == a[31:2]) begin
                    found = 1;
                    d     = data_q[s][i];
                end
            end
            if (found) begin
                exp_hit   = 1;
                exp_miss  = 0;
                exp_instr = d;
            end else begin
                exp_hit   = 0;
                exp_miss  = 1;
                exp_fetch = a & 32'hFFFF_FFFC;
                pending   = 1;
                pend_addr = a;
            end
        end else begin
            exp_hit  = 0;
            exp_miss = 1;
            if (rdy) begin
                s = set_of(pend_addr);
                if (line_q[s].size() == WAYS) begin
                    void'(line_q[s].pop_front());
                    void'(data_q[s].pop_front());
                end
                line_q[s].push_back(pend_addr[31:2]);
                data_q[s].push_back(data);
                exp_instr = data;
                exp_miss  = 0;
                pending   = 0;
            end
        end
    endtask

    // Called at a falling edge: drive inputs, advance the model over the
    // next rising edge, then compare at the following falling edge.
    task automatic tick(input logic [31:0] a, input logic rdy);
        instraddress = a;
        iready       = rdy;
        ifetch       = pending ? mem_word(pend_addr) : $urandom();
        model_step(a, rdy, ifetch);
        @(negedge clk);
        check_outputs();
    endtask

    int n_hits, n_miss;

    // Lookup; on a miss the memory answers one cycle after fetchaddr appears.
    task automatic access(input logic [31:0] a);
        tick(a, 1'b0);
        if (hit)  n_hits++;
        if (miss) n_miss++;
        if (pending) tick(a, 1'b1);
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        iready = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic        rdy;
        instraddress = '0;
        ifetch       = '0;
        iready       = 1'b0;
        reset        = 1'b0;
        n_hits       = 0;
        n_miss       = 0;

        // 1. Reset state.
        do_reset();
        check("rst_instruction", instruction, 32'h0);
        check("rst_fetchaddr", fetchaddr, 32'h0);

        // 2. Two misses into set 4, ways 0 and 1.
        tick(32'h0000_0010, 1'b0);
        n_miss += miss ? 1 : 0;
        n_hits += hit ? 1 : 0;
        check("s2_miss", {31'b0, miss}, 32'd1);
        check("s2_fetchaddr", fetchaddr, 32'h0000_0010);
        tick(32'h0000_0010, 1'b1);
        check("s2_fill_data", instruction, 32'hAA00_0010);
        check("s2_fill_miss", {31'b0, miss}, 32'd0);
        access(32'hAA00_0010);

        // 3. Both resident.
        access(32'h0000_0010);
        check("s3_hit_a", {31'b0, hit}, 32'd1);
        check("s3_data_a", instruction, 32'hAA00_0010);
        access(32'hAA00_0010);
        check("s3_hit_b", {31'b0, hit}, 32'd1);
        check("s3_data_b", instruction, 32'hAA00_0010);

        // 4. Third tag evicts the oldest (0x10); re-access hits.
        access(32'hBB00_0010);
        check("s4_fetchaddr", fetchaddr, 32'hBB00_0010);
        access(32'hBB00_0010);
        check("s4_rehit", {31'b0, hit}, 32'd1);

        // 5. The evicted line misses again.
        access(32'h0000_0010);
        check("s5_evicted_miss", {31'b0, miss}, 32'd0);
        check("s5_evicted_data", instruction, 32'hAA00_0010);
        check("s2_5_hits", n_hits, 32'd3);
        check("s2_5_misses", n_miss, 32'd4);

        // 6a. Address changes while a miss is pending are ignored.
        tick(32'h0000_0100, 1'b0);
        tick(32'h2000_0200, 1'b0);
        check("r1_fetch_held", fetchaddr, 32'h0000_0100);
        tick(32'h3000_0300, 1'b1);
        check("r1_fill_data", instruction, 32'hAA00_0100);
        access(32'h0000_0100);
        check("r1_latched_hit", {31'b0, hit}, 32'd1);
        access(32'h3000_0300);
        check("r1_other_fill", instruction, 32'hAA00_0300);

        // 6b. iready while idle has no effect.
        tick(32'h0000_0100, 1'b1);
        check("r2_hit", {31'b0, hit}, 32'd1);
        tick(32'h0000_0500, 1'b1);
        check("r2_miss", {31'b0, miss}, 32'd1);
        tick(32'h0000_0500, 1'b1);

        // 6c. Reset during a pending miss aborts the fill.
        tick(32'h0000_0400, 1'b0);
        do_reset();
        tick(32'h0000_0400, 1'b1);
        check("r3_post_reset_miss", {31'b0, miss}, 32'd1);
        tick(32'h0000_0400, 1'b1);
        tick(32'h0000_0100, 1'b0);
        check("r3_cleared_line", {31'b0, hit}, 32'd0);
        tick(32'h0000_0100, 1'b1);

        // Randomized traffic over a few sets and tags to force evictions.
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) begin
                a = $urandom();
            end else begin
                a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 2)
                    | 32'($urandom_range(0, 3));
            end
            rdy = pending ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                tick(a, rdy);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
